regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the next generation of the CPU core's register file. It provides NRD combinational read ports and NWR write ports with same-cycle write-to-read bypass and an optional pending-write scoreboard for hazard detection. After reset, a sequencer clears the storage array one register per cycle, because the array itself is never asynchronously reset. It sits between the decode stage (reads, reservations) and the write-back stage (writes).

---
 rtl/regfile_mp_pkg.sv | 20 ++
 rtl/regfile_bypass.sv | 46 ++++
 rtl/regfile_mp.sv | 128 ++++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the regfile_mp multi-port register file: reset level,
// zero word, sequencer state encodings and parameter defaults.
package regfile_mp_pkg;

   localparam logic RST_ACTIVE = 1'b0;

   localparam int DATA_W_DEF = 32;
   localparam int NREGS_DEF  = 32;

   localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Register 0 is hardwired to zero and anything past the top is unmapped.
   function automatic logic addr_ok(input int addr, input int nregs);
      return (addr != 0) && (addr < nregs);
   endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port of regfile_mp: selects same-cycle write data over stored data
// and reports whether a write in this cycle targets the addressed register.
module regfile_bypass
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int NWR    = 2
)(
   input  logic                  i_run,
   input  logic [NWR-1:0]        i_we,
   input  logic [NWR*ADDR_W-1:0] i_waddr,
   input  logic [NWR*DATA_W-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_W-1:0]     i_raddr,
   input  logic [DATA_W-1:0]     i_rd_store,
   output logic [DATA_W-1:0]     o_rdata,
   output logic                  o_hit
);

   logic              w_valid;
   logic              w_match;
   logic [DATA_W-1:0] w_byp;

   assign w_valid = i_run & i_re & addr_ok(32'(i_raddr), NREGS);

   // NOTE: combinational logic uses blocking assignments and gives every
   // output a default first, so no path leaves a value held (no latch).
   always_comb begin
      w_match = 1'b0;
      w_byp   = DATA_W'(ZERO_WORD);
      // Ascending scan: the highest-numbered matching port overrides the rest.
      for (int k = 0; k < NWR; k++) begin
         if (i_we[k] && (i_waddr[k*ADDR_W +: ADDR_W] == i_raddr)) begin
            w_match = 1'b1;
            w_byp   = i_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   assign o_hit   = w_valid & w_match;
   assign o_rdata = !w_valid ? DATA_W'(ZERO_WORD) :
                    (w_match ? w_byp : i_rd_store);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and post-reset clear
// sequencer; define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int ADDR_W = $clog2(NREGS),
   parameter int NRD    = 2,
   parameter int NWR    = 2
)(
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_done,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic [NRD-1:0]        busy
);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_regs [NREGS];

   logic              w_run;
   logic [NRD-1:0]    w_hit;
   logic [ADDR_W-1:0] w_ridx [NRD];

   assign w_run     = (r_state == ST_RUN);
   assign init_done = w_run;

   // Clear counter starts at 1: register 0 is never stored, so it needs no clear.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         r_state <= ST_INIT;
         r_cnt   <= ADDR_W'(1);
      end else if (r_state == ST_INIT) begin
         if (r_cnt == ADDR_W'(NREGS - 1)) begin
            r_state <= ST_RUN;
         end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
         end
      end
   end

   // NOTE: the storage array has no reset; the INIT sequencer zeroes it one
   // entry per cycle, which keeps the array mappable to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_regs[r_cnt] <= DATA_W'(ZERO_WORD);
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (we[k] && addr_ok(32'(waddr[k*ADDR_W +: ADDR_W]), NREGS)) begin
               r_regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;

      assign w_ra      = raddr[i*ADDR_W +: ADDR_W];
      // Out-of-range addresses are steered to entry 0 so the array is never over-indexed.
      assign w_ridx[i] = addr_ok(32'(w_ra), NREGS) ? w_ra : '0;

      regfile_bypass #(
         .DATA_W (DATA_W),
         .NREGS  (NREGS),
         .ADDR_W (ADDR_W),
         .NWR    (NWR)
      ) u_bypass (
         .i_run      (w_run),
         .i_we       (we),
         .i_waddr    (waddr),
         .i_wdata    (wdata),
         .i_re       (re[i]),
         .i_raddr    (w_ra),
         .i_rd_store (r_regs[w_ridx[i]]),
         .o_rdata    (rdata[i*DATA_W +: DATA_W]),
         .o_hit      (w_hit[i])
      );
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREGS-1:0] r_sb;
   logic [NREGS-1:0] w_sb_nxt;

   always_comb begin
      w_sb_nxt = r_sb;
      if (w_run) begin
         for (int k = 0; k < NWR; k++) begin
            if (we[k] && addr_ok(32'(waddr[k*ADDR_W +: ADDR_W]), NREGS)) begin
               w_sb_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
         end
         // Applied after the clears: a reservation is a newer producer than a same-cycle write-back.
         if (rsv_en && addr_ok(32'(rsv_addr), NREGS)) begin
            w_sb_nxt[rsv_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_nxt;
      end
   end

   // sb[0] is never set, so a steered (invalid) index reads as not busy.
   for (genvar i = 0; i < NRD; i++) begin : g_busy
      assign busy[i] = re[i] & r_sb[w_ridx[i]] & ~w_hit[i];
   end
`else
   logic w_unused_sb;

   assign w_unused_sb = ^{rsv_en, rsv_addr, w_hit};
   assign busy        = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance and an NREGS=24 instance
// share stimulus; expectations are queued and checked by an independent monitor.
module tb_regfile_mp;

   typedef struct {
      string       name;
      logic [31:0] rd0, rd1, r24_0, r24_1;
      logic [1:0]  bz, bz24;
      logic        id, id24;
   } exp_t;

`ifdef REGFILE_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  we, re;
   logic [9:0]  waddr, raddr;
   logic [63:0] wdata;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [63:0] rdata, rdata24;
   logic [1:0]  busy, busy24;
   logic        init_done, init_done24;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic g_idone, g_idone24;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) u_dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
   );

   regfile_mp #(.DATA_W(32), .NREGS(24), .NRD(2), .NWR(2)) u_dut24 (
      .clk(clk), .rst(rst), .init_done(init_done24),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(rdata24),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy24)
   );

   // Monitor: outputs are combinational, so every queued entry is compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         n_checks++;
         if ({rdata, busy, init_done, rdata24, busy24, init_done24} !==
             {m_e.rd1, m_e.rd0, m_e.bz, m_e.id, m_e.r24_1, m_e.r24_0, m_e.bz24, m_e.id24}) begin
            $display("FAIL %s: got rd0=%h rd1=%h busy=%b done=%b n24[rd0=%h rd1=%h busy=%b done=%b] expected rd0=%h rd1=%h busy=%b done=%b n24[rd0=%h rd1=%h busy=%b done=%b]",
                     m_e.name, rdata[31:0], rdata[63:32], busy, init_done,
                     rdata24[31:0], rdata24[63:32], busy24, init_done24,
                     m_e.rd0, m_e.rd1, m_e.bz, m_e.id, m_e.r24_0, m_e.r24_1, m_e.bz24, m_e.id24);
         end else begin
            n_pass++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic idle();
      we = '0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0;
   endtask

   task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
      we[k] = 1'b1;
      waddr[k*5 +: 5]   = a;
      wdata[k*32 +: 32] = d;
   endtask

   task automatic rsv(input logic [4:0] a);
      rsv_en = 1'b1; rsv_addr = a;
   endtask

   task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
      re = en; raddr = {a1, a0};
   endtask

   // Queue the expected view of both instances, then let one clock edge pass.
   // Addresses 24..31 are unmapped in the small instance, so it reads 0 / not busy there.
   task automatic step(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb);
      exp_t e;
      e.name    = nm;
      e.rd0     = e0;
      e.rd1     = e1;
      e.bz      = eb;
      e.id      = g_idone;
      e.id24    = g_idone24;
      e.r24_0   = (raddr[4:0] >= 5'd24) ? 32'h0 : e0;
      e.r24_1   = (raddr[9:5] >= 5'd24) ? 32'h0 : e1;
      e.bz24[0] = (raddr[4:0] >= 5'd24) ? 1'b0 : eb[0];
      e.bz24[1] = (raddr[9:5] >= 5'd24) ? 1'b0 : eb[1];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Step e is sampled after e edges since reset release; done rises at edge NREGS-1.
   task automatic init_seq(input bit poke);
      for (int e = 0; e <= 31; e++) begin
         idle();
         if (poke && e < 31) begin
            wr(0, 5'd25, 32'hFFFF_FFFF);
            rsv(5'd25);
         end
         rd(2'b11, 5'd25, 5'd3);
         g_idone   = (e >= 31);
         g_idone24 = (e >= 23);
         step($sformatf("init_e%0d", e), 32'h0, 32'h0, 2'b00);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      rd(2'b11, 5'd5, 5'd3);
      g_idone   = 1'b0;
      g_idone24 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step("reset_state", 32'h0, 32'h0, 2'b00);

      rst = 1'b1;
      init_seq(1'b0);

      for (int i = 0; i < 32; i++) begin
         idle();
         rd(2'b11, 5'(i), 5'(31 - i));
         step($sformatf("clear_rd%0d", i), 32'h0, 32'h0, 2'b00);
      end

      idle(); wr(0, 5'd5, 32'hDEAD_BEEF); rd(2'b11, 5'd5, 5'd0);
      step("bypass_wr5", 32'hDEAD_BEEF, 32'h0, 2'b00);
      idle(); rd(2'b11, 5'd5, 5'd0);
      step("seq_rd5", 32'hDEAD_BEEF, 32'h0, 2'b00);

      idle(); wr(0, 5'd7, 32'h1111_1111); wr(1, 5'd7, 32'h2222_2222); rd(2'b11, 5'd7, 5'd5);
      step("collide_bypass", 32'h2222_2222, 32'hDEAD_BEEF, 2'b00);
      idle(); rd(2'b11, 5'd7, 5'd7);
      step("collide_reg", 32'h2222_2222, 32'h2222_2222, 2'b00);

      idle(); wr(0, 5'd0, 32'hFFFF_FFFF); rd(2'b11, 5'd0, 5'd7);
      step("r0_write", 32'h0, 32'h2222_2222, 2'b00);
      idle(); rd(2'b11, 5'd0, 5'd0);
      step("r0_read", 32'h0, 32'h0, 2'b00);

      idle(); wr(1, 5'd30, 32'h1234_5678); rd(2'b11, 5'd30, 5'd6);
      step("range_bypass", 32'h1234_5678, 32'h0, 2'b00);
      idle(); rd(2'b11, 5'd30, 5'd6);
      step("range_read", 32'h1234_5678, 32'h0, 2'b00);

      idle(); rd(2'b01, 5'd5, 5'd7);
      step("re_masked", 32'hDEAD_BEEF, 32'h0, 2'b00);

      idle(); rsv(5'd9); rd(2'b11, 5'd9, 5'd9);
      step("rsv_same_cycle", 32'h0, 32'h0, 2'b00);
      idle(); rd(2'b11, 5'd9, 5'd5);
      step("rsv_busy_next", 32'h0, 32'hDEAD_BEEF, {1'b0, SB});
      idle(); wr(0, 5'd9, 32'hA5A5_A5A5); rd(2'b11, 5'd9, 5'd9);
      step("wb_suppress", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b00);
      idle(); rd(2'b11, 5'd9, 5'd9);
      step("wb_cleared", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b00);

      idle(); rsv(5'd9); wr(1, 5'd9, 32'h5A5A_5A5A); rd(2'b11, 5'd9, 5'd9);
      step("rsv_wr_same", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 2'b00);
      idle(); rd(2'b11, 5'd9, 5'd9);
      step("rsv_wins", 32'h5A5A_5A5A, 32'h5A5A_5A5A, {SB, SB});
      idle(); rd(2'b10, 5'd9, 5'd9);
      step("busy_re_gate", 32'h0, 32'h5A5A_5A5A, {SB, 1'b0});
      idle(); rsv(5'd0); rd(2'b11, 5'd0, 5'd9);
      step("rsv_r0", 32'h0, 32'h5A5A_5A5A, {SB, 1'b0});
      idle(); rd(2'b11, 5'd0, 5'd9);
      step("rsv_r0_next", 32'h0, 32'h5A5A_5A5A, {SB, 1'b0});

      idle(); wr(0, 5'd3, 32'h5); rd(2'b11, 5'd3, 5'd9);
      step("wr3_bypass", 32'h5, 32'h5A5A_5A5A, {SB, 1'b0});
      idle(); rd(2'b11, 5'd3, 5'd9);
      step("wr3_read", 32'h5, 32'h5A5A_5A5A, {SB, 1'b0});

      idle(); rst = 1'b0; rd(2'b11, 5'd3, 5'd9);
      g_idone   = 1'b0;
      g_idone24 = 1'b0;
      step("mid_reset", 32'h0, 32'h0, 2'b00);
      rst = 1'b1;
      init_seq(1'b1);

      idle(); rd(2'b11, 5'd3, 5'd9);
      step("post_reset_rd3", 32'h0, 32'h0, 2'b00);
      idle(); rd(2'b11, 5'd25, 5'd3);
      step("init_writes_ignored", 32'h0, 32'h0, 2'b00);

      idle();
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
      end else begin
         n_pass++;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
